// File: rtl/led_pulse_driver_pkg.sv
// Shared definitions for the LED/buzzer pulse driver and its sibling long-press detector.
// Holds the FSM state encoding and the board timing constants.
package led_pulse_driver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    localparam int unsigned CLK_HZ         = 100000000;
    localparam int unsigned ONE_SEC_CYCLES = 100000000;

    // Terminal value for an interval of n cycles, truncated to the counter width.
    function automatic logic [31:0] last_tick(input int unsigned n);
        return 32'(n - 1);
    endfunction

endpackage

// File: rtl/led_pulse_driver_interval_timer.sv
// Free-running interval counter with synchronous clear, count enable and a
// terminal flag that compares against a limit supplied at run time.
module led_pulse_driver_interval_timer #(
    parameter int unsigned CNT_W = 27
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] limit,
    output logic             terminal
);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign terminal = (count_reg == limit);

endmodule

// File: rtl/led_pulse_driver.sv
// Turns a one-cycle start request into count timed high pulses on led_out,
// with abort on cancel and a done strobe on normal completion.
module led_pulse_driver
    import led_pulse_driver_pkg::*;
#(
    parameter int unsigned ON_CYCLES  = ONE_SEC_CYCLES,
    parameter int unsigned OFF_CYCLES = ONE_SEC_CYCLES / 2,
    parameter int unsigned CNT_W      = 27,
    parameter int unsigned REP_W      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [REP_W-1:0] count,
    input  logic             cancel,
    output logic             led_out,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] ON_LIMIT  = CNT_W'(last_tick(ON_CYCLES));
    localparam logic [CNT_W-1:0] OFF_LIMIT = CNT_W'(last_tick(OFF_CYCLES));

    state_t           state_reg, state_next;
    logic [REP_W-1:0] remaining_reg, remaining_next;
    logic             led_reg, busy_reg, done_reg;

    logic             timer_clear;
    logic             timer_enable;
    logic [CNT_W-1:0] timer_limit;
    logic             timer_terminal;

    led_pulse_driver_interval_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (timer_clear),
        .enable   (timer_enable),
        .limit    (timer_limit),
        .terminal (timer_terminal)
    );

    always_comb begin
        state_next     = state_reg;
        remaining_next = remaining_reg;
        timer_clear    = 1'b0;
        timer_enable   = 1'b0;
        timer_limit    = ON_LIMIT;

        case (state_reg)
            ST_IDLE: begin
                // cancel outranks a simultaneous start
                if (start && !cancel) begin
                    if (count != '0) begin
                        state_next     = ST_ON;
                        remaining_next = count;
                        timer_clear    = 1'b1;
                    end else begin
                        state_next = ST_FIN;
                    end
                end
            end

            ST_ON: begin
                timer_limit = ON_LIMIT;
                if (cancel) begin
                    state_next     = ST_IDLE;
                    remaining_next = '0;
                    timer_clear    = 1'b1;
                end else begin
                    timer_enable = 1'b1;
                    if (timer_terminal) begin
                        timer_clear = 1'b1;
                        if (remaining_reg != '0) begin
                            remaining_next = remaining_reg - 1'b1;
                        end
                        // last pulse ends straight into FIN, no trailing gap
                        if (remaining_reg <= REP_W'(1)) begin
                            state_next = ST_FIN;
                        end else begin
                            state_next = ST_OFF;
                        end
                    end
                end
            end

            ST_OFF: begin
                timer_limit = OFF_LIMIT;
                if (cancel) begin
                    state_next     = ST_IDLE;
                    remaining_next = '0;
                    timer_clear    = 1'b1;
                end else begin
                    timer_enable = 1'b1;
                    if (timer_terminal) begin
                        timer_clear = 1'b1;
                        state_next  = ST_ON;
                    end
                end
            end

            ST_FIN: begin
                state_next = ST_IDLE;
            end

            default: begin
                state_next     = ST_IDLE;
                remaining_next = '0;
                timer_clear    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            remaining_reg <= '0;
            led_reg       <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            remaining_reg <= remaining_next;
            led_reg       <= (state_next == ST_ON);
            busy_reg      <= (state_next == ST_ON) || (state_next == ST_OFF);
            done_reg      <= (state_next == ST_FIN);
        end
    end

    assign led_out = led_reg;
    assign busy    = busy_reg;
    assign done    = done_reg;

endmodule

// File: tb/tb_led_pulse_driver.sv
// Directed bench for led_pulse_driver with ON_CYCLES=4, OFF_CYCLES=3.
module tb_led_pulse_driver;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] count;
    logic       cancel;
    logic       led_out;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;

    led_pulse_driver #(
        .ON_CYCLES  (4),
        .OFF_CYCLES (3),
        .CNT_W      (27),
        .REP_W      (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .count   (count),
        .cancel  (cancel),
        .led_out (led_out),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic l, input logic b, input logic d);
        check({tag, ".led_out"}, led_out, l);
        check({tag, ".busy"},    busy,    b);
        check({tag, ".done"},    done,    d);
        $display("%0t %s led=%b busy=%b done=%b (exp %b %b %b)", $time, tag, led_out, busy, done, l, b, d);
    endtask

    // Drive a one-cycle start and return just after the sampling edge.
    task automatic pulse_start(input logic [3:0] n);
        start = 1'b1;
        count = n;
        tick();
        start = 1'b0;
        count = 4'd0;
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        count  = 4'd0;
        cancel = 1'b0;
        #12;
        check_outs("reset", 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        check_outs("idle_after_release", 1'b0, 1'b0, 1'b0);

        // count=3: 1111 000 1111 000 1111, done on cycle 19
        pulse_start(4'd3);
        for (int i = 1; i <= 18; i++) begin
            check_outs($sformatf("n3_c%0d", i), ((i - 1) % 7) < 4, 1'b1, 1'b0);
            tick();
        end
        check_outs("n3_c19", 1'b0, 1'b0, 1'b1);
        tick();
        check_outs("n3_c20", 1'b0, 1'b0, 1'b0);

        // count=1: 4 high cycles, no OFF phase, done on cycle 5
        pulse_start(4'd1);
        for (int i = 1; i <= 4; i++) begin
            check_outs($sformatf("n1_c%0d", i), 1'b1, 1'b1, 1'b0);
            tick();
        end
        check_outs("n1_c5", 1'b0, 1'b0, 1'b1);
        tick();
        check_outs("n1_c6", 1'b0, 1'b0, 1'b0);

        // count=0: no pulse, immediate done
        pulse_start(4'd0);
        check_outs("n0_c1", 1'b0, 1'b0, 1'b1);
        tick();
        check_outs("n0_c2", 1'b0, 1'b0, 1'b0);

        // count=2 with an ignored start(9) at cycle 2, run to completion
        pulse_start(4'd2);
        for (int i = 1; i <= 11; i++) begin
            if (i == 2) begin
                start = 1'b1;
                count = 4'd9;
            end
            check_outs($sformatf("n2_c%0d", i), ((i - 1) % 7) < 4, 1'b1, 1'b0);
            tick();
            start = 1'b0;
            count = 4'd0;
        end
        check_outs("n2_c12", 1'b0, 1'b0, 1'b1);
        tick();

        // count=2, start(9) at cycle 2, cancel at cycle 6 while in OFF
        pulse_start(4'd2);
        for (int i = 1; i <= 6; i++) begin
            if (i == 2) begin
                start = 1'b1;
                count = 4'd9;
            end
            if (i == 6) cancel = 1'b1;
            check_outs($sformatf("cx_c%0d", i), i <= 4, 1'b1, 1'b0);
            tick();
            start = 1'b0;
            count = 4'd0;
        end
        cancel = 1'b0;
        for (int i = 7; i <= 12; i++) begin
            check_outs($sformatf("cx_c%0d", i), 1'b0, 1'b0, 1'b0);
            tick();
        end

        pulse_start(4'd1);
        for (int i = 1; i <= 4; i++) begin
            check_outs($sformatf("post_cx_c%0d", i), 1'b1, 1'b1, 1'b0);
            tick();
        end
        check_outs("post_cx_c5", 1'b0, 1'b0, 1'b1);
        tick();

        // start and cancel together in IDLE: nothing happens
        start  = 1'b1;
        count  = 4'd3;
        cancel = 1'b1;
        tick();
        start  = 1'b0;
        count  = 4'd0;
        cancel = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            check_outs($sformatf("sc_c%0d", i), 1'b0, 1'b0, 1'b0);
            tick();
        end

        // asynchronous reset mid-pulse
        pulse_start(4'd2);
        tick();
        check_outs("rst_pre", 1'b1, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("rst_async", 1'b0, 1'b0, 1'b0);
        tick();
        check_outs("rst_held", 1'b0, 1'b0, 1'b0);
        #3;
        rst_n = 1'b1;
        tick();
        check_outs("rst_released", 1'b0, 1'b0, 1'b0);
        pulse_start(4'd1);
        for (int i = 1; i <= 4; i++) begin
            check_outs($sformatf("post_rst_c%0d", i), 1'b1, 1'b1, 1'b0);
            tick();
        end
        check_outs("post_rst_c5", 1'b0, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/led_pulse_driver.md
Name: led_pulse_driver

Overview:
- Timed-output generator; it is the driving counterpart of our long-press detector.
- The detector turns a held level into a one-second qualified event. This block does the reverse: it turns a one-cycle request into N timed high pulses on a board output (LED or buzzer).
- It sits between the control FSM (which issues start, count and cancel) and the top-level output pin.

Parameters:
- ON_CYCLES, 100000000: high time per pulse, in clk cycles (1 s at 100 MHz); must be >= 1.
- OFF_CYCLES, 50000000: low gap between consecutive pulses, in clk cycles; must be >= 1.
- CNT_W, 27: width of the timing counter; must hold max(ON_CYCLES, OFF_CYCLES) - 1.
- REP_W, 4: width of the pulse-count request.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous reset, active low.
- start  in  1  one-cycle request strobe; honoured only when idle.
- count  in  REP_W  number of pulses to emit; sampled with start.
- cancel  in  1  abort strobe; level-sensitive, checked every cycle.
- led_out  out  1  registered pulse output.
- busy  out  1  high while a sequence is in progress.
- done  out  1  one-cycle strobe when a sequence completes normally.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; timer = 0; remaining = 0.
  - led_out = 0, busy = 0, done = 0.
  - Release is used synchronously (first active edge after deassertion).
- States: IDLE, ON, OFF, FIN.
- All outputs are registered. busy = (state is ON or OFF). led_out = (state is ON).
- IDLE:
  - start=1, count!=0, cancel=0 at edge k: latch remaining = count, timer = 0, go to ON. led_out and busy are high after edge k.
  - start=1, count=0, cancel=0: go to FIN with no pulse; done is high for the one cycle after edge k.
- ON:
  - timer increments every cycle.
  - When timer = ON_CYCLES-1: timer = 0, remaining decrements.
    - If remaining was 1: go to FIN.
    - Otherwise: go to OFF.
  - Net effect: led_out is high for exactly ON_CYCLES cycles per pulse.
- OFF:
  - timer increments every cycle.
  - When timer = OFF_CYCLES-1: timer = 0, go to ON.
  - led_out is low for exactly OFF_CYCLES cycles. There is no trailing OFF gap after the last pulse.
- FIN:
  - done = 1 for exactly one cycle, busy = 0; return to IDLE next edge.
  - start is ignored while in FIN.
- Latency:
  - From the start edge to the first led_out rise: 0 cycles (visible after the same edge).
  - Total busy duration for N pulses: N*ON_CYCLES + (N-1)*OFF_CYCLES cycles.
  - done asserts on the cycle immediately after the last ON cycle.
- start while busy or in FIN: ignored entirely. count is not resampled and there is no queuing.
- cancel in ON or OFF: next edge goes to IDLE; led_out = 0, busy = 0, timer = 0, remaining = 0. done is NOT pulsed.
- cancel and start together in IDLE: cancel wins; stay IDLE, no done.
- cancel in FIN: done still pulses; the sequence had already completed.
- Arithmetic:
  - The timer compare is equality against the parameter minus 1, truncated to CNT_W bits.
  - remaining is REP_W bits and never wraps: decrement happens only when non-zero.
- Reset mid-sequence: immediate return to reset values; led_out drops asynchronously.

Decomposition:
- Shared package:
  - state encoding for IDLE/ON/OFF/FIN (2-bit);
  - default timing constants CLK_HZ = 100000000, ONE_SEC_CYCLES = 100000000. The long-press detector also uses ONE_SEC_CYCLES.
- One natural sub-module: interval_timer.
  - Function: load/clear, enable, terminal-count compare against a runtime limit, terminal flag output.
  - Instantiated once. The FSM selects the limit ON_CYCLES-1 or OFF_CYCLES-1 by state.

Test Plan (ON_CYCLES=4, OFF_CYCLES=3, REP_W=4 unless noted):
- start=1 with count=3 for one cycle:
  - led_out pattern after the start edge is 1111 000 1111 000 1111 (18 cycles), busy high for all 18;
  - done=1 on cycle 19 only; busy=0 from cycle 19.
- start with count=1: led_out high for exactly 4 cycles, no OFF phase, done on cycle 5.
- start with count=0: led_out never rises, busy never rises, done=1 for one cycle after the start edge.
- start count=2, then start count=9 at cycle 2, then cancel at cycle 6 (in OFF):
  - the second start is ignored and the pulse count stays 2;
  - after cancel, led_out=0 and busy=0 next cycle, done never asserts;
  - a fresh start count=1 afterwards produces a normal 4-cycle pulse.
- Simultaneous start=1, cancel=1 in IDLE: no state change, led_out/busy/done all stay 0.
- Reset behaviour:
  - rst_n low while led_out=1 mid-pulse: led_out=0 without waiting for a clk edge; all outputs 0.
  - After release, the block behaves as fresh IDLE.
  - With defaults (ON_CYCLES=100000000): a single pulse is high for exactly 100000000 cycles (checked by cycle counter).
